product_accumulator: RTL



---
 rtl/mac_pkg.sv | 33 +++
 rtl/acc_sat_adder.sv | 27 ++
 rtl/product_accumulator.sv | 105 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the product accumulator: state encoding,
// sign extension and two's-complement saturation limits.
package mac_pkg;

    localparam int PROD_W_DEF = 64;
    localparam int ACC_W_DEF  = 72;
    // Widest accumulator the helpers below can describe.
    localparam int EXT_W      = 128;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Sign-extend the low w bits of v to EXT_W bits; callers truncate to their width.
    function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] v, input int w);
        logic signed [EXT_W-1:0] t;
        t = v << (EXT_W - w);
        return t >>> (EXT_W - w);
    endfunction

    function automatic logic [EXT_W-1:0] sat_pos(input int w);
        return (EXT_W'(1) << (w - 1)) - EXT_W'(1);
    endfunction

    function automatic logic [EXT_W-1:0] sat_neg(input int w);
        return EXT_W'(1) << (w - 1);
    endfunction

    localparam logic [ACC_W_DEF-1:0] SAT_POS_DEF = ACC_W_DEF'(sat_pos(ACC_W_DEF));
    localparam logic [ACC_W_DEF-1:0] SAT_NEG_DEF = ACC_W_DEF'(sat_neg(ACC_W_DEF));

endpackage

// File: rtl/acc_sat_adder.sv
// Combinational W-bit signed add with overflow detect. Build with
// PRODUCT_ACCUMULATOR_SAT_EN to clamp the sum on overflow instead of wrapping.
module acc_sat_adder
    import mac_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign the result does not.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    assign sum = !ovf   ? raw :
                 a[W-1] ? W'(sat_neg(W)) : W'(sat_pos(W));
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums framed streams of signed products into a wide accumulator and hands each
// frame result downstream. Optional saturation: PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  term_count,
    output logic              overflow
);

    if (ACC_W < PROD_W || ACC_W > EXT_W) begin : g_bad_acc_w
        $error("product_accumulator: ACC_W must lie in PROD_W..%0d", EXT_W);
    end
    if (MAX_TERMS < 1 || MAX_TERMS > (2 ** CNT_W) - 1) begin : g_bad_max_terms
        $error("product_accumulator: MAX_TERMS must lie in 1..2^CNT_W-1");
    end

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [ACC_W-1:0]   ext;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic               close;
    logic               release_res;

    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == HOLD);

    assign ext         = ACC_W'(sext(EXT_W'(product), PROD_W));
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign accept      = in_valid & in_ready;
    // in_last on the beat that also reaches MAX_TERMS still closes only once.
    assign close       = accept & (in_last | (cnt_inc == CNT_W'(MAX_TERMS)));
    assign release_res = out_valid & out_ready;

    acc_sat_adder #(
        .W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)     state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default:                state_d = ACCUM;
        endcase
    end

    // Running sum and the captured frame result; the capture holds through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            acc_out    <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= sum;
                cnt_q <= cnt_inc;
                ovf_q <= ovf_q | add_ovf;
            end
            if (close) begin
                acc_out    <= sum;
                term_count <= cnt_inc;
                overflow   <= ovf_q | add_ovf;
            end
            if (release_res) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

endmodule
